// File: rtl/dot_matrix_scan_if.sv
// Frame-source handshake between the pattern generator and the matrix scanner.
// Carries the flat frame, the valid/ready pair and the brightness duty.
interface dot_matrix_scan_if #(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
);
    logic [ROWS*COLS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic [7:0]           bright;

    modport master (output data, output valid, output bright, input ready);
    modport slave  (input data, input valid, input bright, output ready);
endinterface

// File: rtl/dot_matrix_scan.sv
// Multiplexed LED-matrix scanner: double-buffered frame, per-slot blanking,
// 8-bit PWM brightness and selectable row/column drive polarity.
module dot_matrix_scan #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned ROW_TICKS      = 100000,
    parameter int unsigned BLANK_TICKS    = 50,
    parameter bit          ROW_ACTIVE_LOW = 1'b0,
    parameter bit          COL_ACTIVE_LOW = 1'b0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    dot_matrix_scan_if.slave          frm,
    output logic [ROWS-1:0]           o_DM_Row,
    output logic [COLS-1:0]           o_DM_Col,
    output logic [$clog2(ROWS)-1:0]   o_Row_Idx,
    output logic                      o_fDone
);

    localparam int unsigned CW = $clog2(ROW_TICKS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [CW-1:0] CNT_LAST = CW'(ROW_TICKS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    pwm_q, pwm_d;
    logic [7:0]    bright_q, bright_d;
    frame_t        disp_q, disp_d;
    frame_t        pend_q, pend_d;
    logic          pend_full_q, pend_full_d;

    logic slot_end_c;
    logic frame_end_c;
    logic blank_c;
    logic pwm_en_c;
    logic accept_c;
    logic [ROWS-1:0] row_on_c;
    logic [COLS-1:0] col_on_c;

    assign slot_end_c  = (cnt_q == CNT_LAST);
    assign frame_end_c = slot_end_c && (row_q == ROW_LAST);
    assign blank_c     = (32'(cnt_q) < BLANK_TICKS);
    assign pwm_en_c    = (pwm_q < bright_q) || (bright_q == 8'hFF);
    assign accept_c    = frm.valid && !pend_full_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q       <= '0;
            row_q       <= '0;
            pwm_q       <= '0;
            bright_q    <= 8'hFF;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pwm_q       <= pwm_d;
            bright_q    <= bright_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q + CW'(1);
        row_d       = row_q;
        pwm_d       = pwm_q;
        bright_d    = bright_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (slot_end_c) begin
            cnt_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end

        // PWM is held at zero through blanking so it reads 0 on the first lit cycle
        if (slot_end_c || blank_c) begin
            pwm_d = '0;
        end else if (pwm_q != 8'hFF) begin
            pwm_d = pwm_q + 8'd1;
        end

        // Only a frame pending before this cycle is swapped; same-cycle accepts wait a frame
        if (frame_end_c) begin
            bright_d = frm.bright;
            if (pend_full_q) begin
                disp_d      = pend_q;
                pend_full_d = 1'b0;
            end
        end

        if (accept_c) begin
            pend_d      = frm.data;
            pend_full_d = 1'b1;
        end
    end

    always_comb begin
        row_on_c = '0;
        col_on_c = '0;
        if (!blank_c) begin
            row_on_c = ROWS'(1) << row_q;
            if (pwm_en_c) begin
                col_on_c = disp_q[row_q];
            end
        end
    end

    assign o_DM_Row  = row_on_c ^ {ROWS{ROW_ACTIVE_LOW}};
    assign o_DM_Col  = col_on_c ^ {COLS{COL_ACTIVE_LOW}};
    assign o_Row_Idx = row_q;
    assign o_fDone   = frame_end_c;
    assign frm.ready = !pend_full_q;

endmodule

// File: doc/dot_matrix_scan.md
# dot_matrix_scan

Parametrised multiplexed LED-matrix scanner, successor to the fixed 8x8 row scanner. Drives ROWS row lines and COLS column lines from a double-buffered frame, with a per-row blanking window against ghosting, 8-bit PWM brightness and selectable drive polarity. It sits between the frame/pattern generator (valid/ready frame source) and the board matrix pins, and provides a frame-done pulse for pattern sequencing.

## Interface
- ROWS, 8, number of row lines (2..32)
- COLS, 8, number of column lines (1..32)
- ROW_TICKS, 100000, clocks per row slot (2 ms at 50 MHz); must be >= 2
- BLANK_TICKS, 50, clocks at the start of each slot with rows and columns off; must be < ROW_TICKS
- ROW_ACTIVE_LOW, 0, 1 inverts all o_DM_Row bits
- COL_ACTIVE_LOW, 0, 1 inverts all o_DM_Col bits
- i_Clk  in  1  system clock (50 MHz)
- i_Rst  in  1  asynchronous, active-high reset
- i_Data  in  ROWS*COLS  frame; row r is i_Data[COLS*r +: COLS], bit c lights column c
- i_Valid  in  1  frame offered on i_Data
- o_Ready  out  1  pending buffer empty; frame accepted when i_Valid && o_Ready
- i_Bright  in  8  brightness duty, sampled at frame boundary
- o_DM_Row  out  ROWS  one-hot row drive (after polarity)
- o_DM_Col  out  COLS  column drive (after polarity)
- o_Row_Idx  out  $clog2(ROWS)  index of row currently being scanned
- o_fDone  out  1  one-cycle pulse on the last clock of the last row slot

## Operation
- Registers: slot counter c_Cnt (0..ROW_TICKS-1), row index c_Row (0..ROWS-1), PWM counter (8 bit), display buffer, pending buffer plus pending-full flag, brightness register.
- c_Cnt increments every clock and wraps to 0 at ROW_TICKS-1. On wrap, c_Row advances by 1; from ROWS-1 it returns to 0. That wrap point is the frame boundary.
- Blank phase, c_Cnt < BLANK_TICKS: all rows and all columns are logically off.
- Active phase, c_Cnt >= BLANK_TICKS: row c_Row is logically on. Columns are display row c_Row ANDed with the PWM enable.
- PWM counter: 0 at the first active cycle of each slot, +1 per clock, saturates at 255.
- PWM enable: (pwm < bright_reg) || (bright_reg == 8'hFF).
- Polarity inversion is applied last. Outputs decode combinationally from registered state and carry no extra latency.
- Frame input:
  - i_Valid && o_Ready copies i_Data into the pending buffer and sets pending-full. o_Ready = !pending-full.
  - At the frame boundary, if pending-full was already set in that cycle, the pending buffer moves to the display buffer and pending-full clears.
  - i_Bright is latched into bright_reg on every frame boundary.
- A frame accepted in the boundary cycle itself is not swapped at that boundary. It is displayed from the following boundary.
- i_Valid while o_Ready=0 is ignored. Pending contents are unchanged.

## Timing
- Reset (async, immediate):
  - c_Cnt = 0, c_Row = 0, PWM = 0.
  - Display buffer = 0, pending empty (o_Ready = 1).
  - bright_reg = 8'hFF.
  - o_fDone = 0, o_Row_Idx = 0.
  - Rows and columns at the off level: 0, or all-ones when the matching ACTIVE_LOW parameter is 1.
- First slot after reset begins in blank phase.
- o_fDone is high exactly when c_Row == ROWS-1 && c_Cnt == ROW_TICKS-1, once per ROWS*ROW_TICKS clocks.
- o_Ready falls the cycle after an accept. It rises the cycle after the swap.
- A new frame first appears at the start of row 0 following the swap. Frame-to-display latency is at most 2*ROWS*ROW_TICKS clocks.
- Reset asserted mid-slot or mid-frame discards the display and pending buffers. Scanning restarts at row 0, c_Cnt 0.
- Row line switching happens only at slot starts. Rows and columns are off for exactly BLANK_TICKS clocks per slot, so no two rows are ever on in the same cycle.

## Test plan
Parameters: ROWS=4, COLS=4, ROW_TICKS=10, BLANK_TICKS=2 unless noted.
1. Reset check: assert i_Rst, then release.
   - During reset: o_DM_Row=0, o_DM_Col=0, o_Ready=1, o_fDone=0.
   - After release: o_fDone pulses at cycles 39, 79, ...
2. Frame load: i_Data=16'h8421 with i_Valid for 1 cycle.
   - o_Ready=0 until the next boundary.
   - The following frame shows row0 cols 4'h1, row1 4'h2, row2 4'h4, row3 4'h8, each on slot cycles 2..9.
   - o_DM_Row/o_DM_Col are 0 on slot cycles 0..1.
3. Brightness with frame 16'hFFFF:
   - i_Bright=4: cols 4'hF on slot cycles 2..5 and 0 on cycles 6..9.
   - i_Bright=0: cols always 0.
   - i_Bright=8'hFF: cols on for all of cycles 2..9.
   - Each change takes effect only after the next boundary.
4. Back-pressure and boundary accept:
   - Offer 16'h1111, then offer 16'h2222 while o_Ready=0: display shows 16'h1111 and 16'h2222 is never shown.
   - An accept in the o_fDone cycle is displayed one full frame later.
5. Polarity with ROW_ACTIVE_LOW=1, COL_ACTIVE_LOW=1 and frame 16'h8421: row0 active gives o_DM_Row=4'b1110 and o_DM_Col=4'b1110. Blank phase gives 4'hF on both.
6. Async reset mid-slot: assert i_Rst at c_Row=2, c_Cnt=5 without a clock edge.
   - Outputs go to the off level immediately.
   - After release, scanning restarts at row 0 with display blank.
